// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply-divide unit: iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU
// with MTHI/MTLO writes; results are committed to Hi/Lo only in the FIX state.
module hilo_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [DATA_WIDTH-1:0] OperandA,
    input  logic [DATA_WIDTH-1:0] OperandB,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [W-1:0]   ONE_W   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_2W  = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  ONE_CW  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  LAST_CW = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic            is_signed_s, is_div_s, in_signed_s;
    logic [W-1:0]    a_mag_s, b_mag_s, in_a_mag_s, in_b_mag_s;
    logic [W:0]      mul_sum_s, div_trial_s, div_diff_s;
    logic            div_ge_s;
    logic [2*W-1:0]  mul_next_s, div_next_s, prod_s;
    logic [W-1:0]    quot_s, rem_s;
    logic            signs_differ_s, div_zero_s;

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic sgn);
        magnitude = (sgn && x[W-1]) ? (~x + ONE_W) : x;
    endfunction

    // Datapath: operand magnitudes, one shift-add / restoring-subtract step, sign fix-up.
    always_comb begin
        is_signed_s    = (op_q == OP_MULT) || (op_q == OP_DIV);
        is_div_s       = (op_q == OP_DIV) || (op_q == OP_DIVU);
        in_signed_s    = (Op == OP_MULT) || (Op == OP_DIV);
        a_mag_s        = magnitude(a_q, is_signed_s);
        b_mag_s        = magnitude(b_q, is_signed_s);
        in_a_mag_s     = magnitude(OperandA, in_signed_s);
        in_b_mag_s     = magnitude(OperandB, in_signed_s);

        // Multiply: acc = {partial product, remaining multiplier bits}, shifts right.
        mul_sum_s      = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_mag_s} : {(W+1){1'b0}});
        mul_next_s     = {mul_sum_s, acc_q[W-1:1]};

        // Divide: acc = {partial remainder, dividend/quotient bits}, shifts left.
        div_trial_s    = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff_s     = div_trial_s - {1'b0, b_mag_s};
        div_ge_s       = (div_trial_s >= {1'b0, b_mag_s});
        div_next_s     = div_ge_s ? {div_diff_s[W-1:0], acc_q[W-2:0], 1'b1}
                                  : {div_trial_s[W-1:0], acc_q[W-2:0], 1'b0};

        signs_differ_s = is_signed_s && (a_q[W-1] ^ b_q[W-1]);
        div_zero_s     = (b_q == {W{1'b0}});
        prod_s         = signs_differ_s ? (~acc_q + ONE_2W) : acc_q;
        quot_s         = signs_differ_s ? (~acc_q[W-1:0] + ONE_W) : acc_q[W-1:0];
        rem_s          = (is_signed_s && a_q[W-1]) ? (~acc_q[2*W-1:W] + ONE_W)
                                                   : acc_q[2*W-1:W];
    end

    // FSM next-state and register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MULT, OP_MULTU: begin
                            op_d    = Op;
                            a_d     = OperandA;
                            b_d     = OperandB;
                            cnt_d   = {CW{1'b0}};
                            acc_d   = {{W{1'b0}}, in_b_mag_s};
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = Op;
                            a_d     = OperandA;
                            b_d     = OperandB;
                            cnt_d   = {CW{1'b0}};
                            acc_d   = {{W{1'b0}}, in_a_mag_s};
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = OperandA;
                        OP_MTLO: lo_d = OperandA;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = is_div_s ? div_next_s : mul_next_s;
                cnt_d = cnt_q + ONE_CW;
                if (cnt_q == LAST_CW) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIX: begin
                if (is_div_s) begin
                    if (div_zero_s) begin
                        lo_d = {W{1'b1}};
                        hi_d = a_q;
                    end else begin
                        lo_d = quot_s;
                        hi_d = rem_s;
                    end
                end else begin
                    lo_d = prod_s[W-1:0];
                    hi_d = prod_s[2*W-1:W];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and architectural registers; reset aborts any operation in flight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            op_q    <= 3'b000;
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            acc_q   <= {(2*W){1'b0}};
            hi_q    <= {W{1'b0}};
            lo_q    <= {W{1'b0}};
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule
